// File: rtl/operand_target_dispatcher_pkg.sv
// Shared types for the operand egress path: operand and target encodings,
// the FIFO entry layout used by the dispatcher, and the dispatcher FSM state.
package operand_target_dispatcher_pkg;

   localparam int INSTR_W = 7;
   localparam int DATA_W  = 64;

   localparam logic [1:0] SLOT_LEFT  = 2'd0;
   localparam logic [1:0] SLOT_RIGHT = 2'd1;
   localparam logic [1:0] SLOT_PRED  = 2'd2;
   localparam logic [1:0] SLOT_BAD   = 2'd3;

   typedef logic [INSTR_W-1:0] instr_num_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              valid;
      instr_num_t        source_instr;
   } operand_t;

   typedef struct packed {
      logic       vld;
      instr_num_t instr;
      logic [1:0] slot;
   } op_target_t;

   typedef struct packed {
      operand_t   operand;
      op_target_t tgt0;
      op_target_t tgt1;
   } disp_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND0 = 2'd1,
      ST_SEND1 = 2'd2
   } disp_state_t;

   // A target addressed to the unused slot encoding is treated as absent.
   function automatic op_target_t sanitize_target(input op_target_t t);
      op_target_t r;
      r = t;
      if (t.slot == SLOT_BAD) r.vld = 1'b0;
      return r;
   endfunction

   function automatic logic target_slot_err(input op_target_t t);
      return t.vld && (t.slot == SLOT_BAD);
   endfunction

endpackage

// File: rtl/op_result_fifo.sv
// Parameterised synchronous FIFO for executed results.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush          discard contents (see keep_head)
//   keep_head      during flush, retain the head entry (it is in flight)
//   push, din      write at tail when not full
//   pop            retire head when not empty
//   dout           head entry (registered storage, no bypass from din)
//   count          valid entries, one bit wider than the pointers
//   full, empty    status
module op_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   keep_head,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_BW = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_BW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full && !flush;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         // A head still on the wire survives the flush unless it retires now.
         if (keep_head && !empty && !rd_en) begin
            wr_ptr <= rd_ptr + PTR_W'(1);
            count  <= CNT_BW'(1);
         end else begin
            rd_ptr <= rd_ptr + PTR_W'(rd_en);
            wr_ptr <= rd_ptr + PTR_W'(rd_en);
            count  <= '0;
         end
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_BW'(wr_en) - CNT_BW'(rd_en);
      end
   end

endmodule

// File: rtl/operand_target_dispatcher.sv
// Egress stage in front of one local port of the operand network.
// Queues executed results and emits one req/ack flit per valid target.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     block flush, one-cycle pulse
//   res_valid/res_ready       result input handshake
//   res_operand/tgt0/tgt1     result value and its up to two targets
//   net_req/net_ack           network local handshake
//   net_operand/dest_*        flit payload, stable while net_req is held
//   occupancy, busy           FIFO fill and activity status
//   slot_err                  sticky: a valid target used slot encoding 3
//   flits_sent                wrapping count of acked flits
//
// state    | meaning
// ST_IDLE  | no flit on the wire; waiting for a head entry
// ST_SEND0 | head tgt0 flit driven, waiting for ack
// ST_SEND1 | head tgt1 flit driven, waiting for ack
module operand_target_dispatcher
   import operand_target_dispatcher_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   res_valid,
   output logic                   res_ready,
   input  operand_t               res_operand,
   input  op_target_t             res_tgt0,
   input  op_target_t             res_tgt1,
   output logic                   net_req,
   input  logic                   net_ack,
   output operand_t               net_operand,
   output instr_num_t             net_dest_instr,
   output logic [1:0]             net_dest_slot,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   busy,
   output logic                   slot_err,
   output logic [CNT_W-1:0]       flits_sent
);

   localparam int ENTRY_W = $bits(disp_entry_t);

   disp_state_t  state;
   disp_state_t  state_nxt;
   disp_entry_t  head;
   disp_entry_t  in_entry;
   logic [ENTRY_W-1:0] head_bits;
   op_target_t   tgt0_s;
   op_target_t   tgt1_s;
   logic         accept;
   logic         push;
   logic         pop;
   logic         fire;
   logic         fifo_full;
   logic         fifo_empty;
   logic         drop_q;

   assign tgt0_s   = sanitize_target(res_tgt0);
   assign tgt1_s   = sanitize_target(res_tgt1);
   assign accept   = res_valid && res_ready;
   // Results with nothing left to deliver are consumed without a FIFO slot.
   assign push     = accept && (tgt0_s.vld || tgt1_s.vld) && !flush;
   assign in_entry = '{operand: res_operand, tgt0: tgt0_s, tgt1: tgt1_s};
   assign head     = disp_entry_t'(head_bits);
   assign fire     = net_req && net_ack;

   op_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .keep_head (net_req),
      .push      (push),
      .din       (in_entry),
      .pop       (pop),
      .dout      (head_bits),
      .count     (occupancy),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign res_ready = !fifo_full;
   assign busy      = (occupancy != '0) || net_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !flush)
               state_nxt = head.tgt0.vld ? ST_SEND0 : ST_SEND1;
         end
         ST_SEND0: begin
            if (net_ack) begin
               // A flush seen earlier or now cancels the second target.
               if (head.tgt1.vld && !flush && !drop_q) begin
                  state_nxt = ST_SEND1;
               end else begin
                  state_nxt = ST_IDLE;
                  pop       = 1'b1;
               end
            end
         end
         ST_SEND1: begin
            if (net_ack) begin
               state_nxt = ST_IDLE;
               pop       = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      net_req        = 1'b0;
      net_operand    = '0;
      net_dest_instr = '0;
      net_dest_slot  = '0;
      case (state)
         ST_SEND0: begin
            net_req        = 1'b1;
            net_operand    = head.operand;
            net_dest_instr = head.tgt0.instr;
            net_dest_slot  = head.tgt0.slot;
         end
         ST_SEND1: begin
            net_req        = 1'b1;
            net_operand    = head.operand;
            net_dest_instr = head.tgt1.instr;
            net_dest_slot  = head.tgt1.slot;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   drop_q <= 1'b0;
      else if (fire)             drop_q <= 1'b0;
      else if (flush && net_req) drop_q <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       flits_sent <= '0;
      else if (fire) flits_sent <= flits_sent + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         slot_err <= 1'b0;
      else if (accept && (target_slot_err(res_tgt0) || target_slot_err(res_tgt1)))
         slot_err <= 1'b1;
   end

endmodule

// File: tb/tb_operand_target_dispatcher.sv
module tb_operand_target_dispatcher;
   import operand_target_dispatcher_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       res_valid;
   logic       res_ready;
   operand_t   res_operand;
   op_target_t res_tgt0;
   op_target_t res_tgt1;
   logic       net_req;
   logic       net_ack;
   operand_t   net_operand;
   instr_num_t net_dest_instr;
   logic [1:0] net_dest_slot;
   logic [2:0] occupancy;
   logic       busy;
   logic       slot_err;
   logic [15:0] flits_sent;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] data;
      logic [6:0]  instr;
      logic [1:0]  slot;
   } flit_t;
   flit_t exp_q[$];

   always #5 clk = ~clk;

   operand_target_dispatcher #(.DEPTH(4), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_operand    (res_operand),
      .res_tgt0       (res_tgt0),
      .res_tgt1       (res_tgt1),
      .net_req        (net_req),
      .net_ack        (net_ack),
      .net_operand    (net_operand),
      .net_dest_instr (net_dest_instr),
      .net_dest_slot  (net_dest_slot),
      .occupancy      (occupancy),
      .busy           (busy),
      .slot_err       (slot_err),
      .flits_sent     (flits_sent)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic op_target_t tg(input logic v, input int instr, input int slot);
      op_target_t t;
      t.vld   = v;
      t.instr = 7'(instr);
      t.slot  = 2'(slot);
      return t;
   endfunction

   function automatic operand_t opnd(input logic [63:0] d);
      operand_t o;
      o.data         = d;
      o.valid        = 1'b1;
      o.source_instr = 7'd1;
      return o;
   endfunction

   task automatic expect_flit(input logic [63:0] d, input int instr, input int slot);
      flit_t f;
      f.data  = d;
      f.instr = 7'(instr);
      f.slot  = 2'(slot);
      exp_q.push_back(f);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_res(input logic [63:0] d, input op_target_t t0, input op_target_t t1);
      res_valid   = 1'b1;
      res_operand = opnd(d);
      res_tgt0    = t0;
      res_tgt1    = t1;
   endtask

   task automatic push_one(input logic [63:0] d, input op_target_t t0, input op_target_t t1);
      tick();
      drive_res(d, t0, t1);
      tick();
      res_valid = 1'b0;
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (net_req) break;
      end
      check(name, 128'(net_req), 128'(1));
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(name, 128'(busy), 128'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   128'(net_req), 128'(0));
      check({tag, "_ready"}, 128'(res_ready), 128'(1));
      check({tag, "_occ"},   128'(occupancy), 128'(0));
      check({tag, "_busy"},  128'(busy), 128'(0));
      check({tag, "_serr"},  128'(slot_err), 128'(0));
      check({tag, "_cnt"},   128'(flits_sent), 128'(0));
      check({tag, "_flit"},  128'({net_operand.data, net_dest_instr, net_dest_slot}), 128'(0));
   endtask

   // Monitor: every completed transfer is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && net_req && net_ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_flit", 128'({net_dest_instr, net_dest_slot}), 128'({7'h7f, 2'd3}) + 128'(1));
            end else begin
               flit_t f;
               f = exp_q.pop_front();
               check("flit", 128'({net_operand.data, net_dest_instr, net_dest_slot}),
                     128'({f.data, f.instr, f.slot}));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; res_valid = 1'b0; net_ack = 1'b0;
      res_operand = '0; res_tgt0 = '0; res_tgt1 = '0;
      @(negedge clk);
      check_reset_outputs("reset");
      tick();
      rst = 1'b0;

      // 1: two targets, ack held high -> back-to-back flits
      net_ack = 1'b1;
      expect_flit(64'hA5, 5, 0);
      expect_flit(64'hA5, 9, 2);
      push_one(64'hA5, tg(1, 5, 0), tg(1, 9, 2));
      wait_req("t1_req0");
      check("t1_first_dest", 128'({net_dest_instr, net_dest_slot}), 128'({7'd5, 2'd0}));
      @(negedge clk);
      check("t1_second_req", 128'(net_req), 128'(1));
      check("t1_second_dest", 128'({net_dest_instr, net_dest_slot}), 128'({7'd9, 2'd2}));
      @(negedge clk);
      check("t1_req_drop", 128'(net_req), 128'(0));
      check("t1_cnt", 128'(flits_sent), 128'(2));
      check("t1_occ", 128'(occupancy), 128'(0));

      // 2: held flit stays stable while ack is low
      net_ack = 1'b0;
      expect_flit(64'h3C, 7, 1);
      push_one(64'h3C, tg(1, 7, 1), tg(0, 0, 0));
      wait_req("t2_req");
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         check("t2_hold", 128'({net_req, net_operand.data, net_dest_instr, net_dest_slot}),
               128'({1'b1, 64'h3C, 7'd7, 2'd1}));
      end
      tick();
      net_ack = 1'b1;
      @(negedge clk);
      check("t2_hold_last", 128'({net_req, net_operand.data, net_dest_instr, net_dest_slot}),
            128'({1'b1, 64'h3C, 7'd7, 2'd1}));
      tick();
      net_ack = 1'b0;
      @(negedge clk);
      check("t2_cnt", 128'(flits_sent), 128'(3));
      check("t2_req_drop", 128'(net_req), 128'(0));

      // 3: fill the FIFO, fifth result refused, one ack frees a slot
      expect_flit(64'h01, 1, 0);
      expect_flit(64'h02, 2, 1);
      expect_flit(64'h03, 3, 0);
      expect_flit(64'h04, 4, 2);
      tick();
      drive_res(64'h01, tg(1, 1, 0), tg(0, 0, 0)); tick();
      drive_res(64'h02, tg(1, 2, 1), tg(0, 0, 0)); tick();
      drive_res(64'h03, tg(1, 3, 0), tg(0, 0, 0)); tick();
      drive_res(64'h04, tg(0, 0, 0), tg(1, 4, 2)); tick();
      drive_res(64'h05, tg(1, 6, 0), tg(0, 0, 0));
      @(negedge clk);
      check("t3_full_ready", 128'(res_ready), 128'(0));
      check("t3_full_occ", 128'(occupancy), 128'(4));
      tick();
      res_valid = 1'b0;
      net_ack   = 1'b1;
      @(negedge clk);
      check("t3_fifth_refused", 128'(occupancy), 128'(4));
      tick();
      net_ack = 1'b0;
      @(negedge clk);
      check("t3_ready_again", 128'(res_ready), 128'(1));
      check("t3_occ_after_pop", 128'(occupancy), 128'(3));
      tick();
      net_ack = 1'b1;
      wait_idle("t3_drain");
      check("t3_cnt", 128'(flits_sent), 128'(7));

      // 4: tgt0 invalid -> only tgt1; no targets -> dropped
      expect_flit(64'h77, 3, 1);
      push_one(64'h77, tg(0, 8, 0), tg(1, 3, 1));
      wait_idle("t4_idle");
      tick();
      drive_res(64'h88, tg(0, 2, 0), tg(0, 4, 1));
      @(negedge clk);
      check("t4_drop_ready", 128'(res_ready), 128'(1));
      tick();
      res_valid = 1'b0;
      @(negedge clk);
      check("t4_drop_occ", 128'(occupancy), 128'(0));
      @(negedge clk);
      check("t4_drop_req", 128'(net_req), 128'(0));
      check("t4_cnt", 128'(flits_sent), 128'(8));

      // 5: flush while SEND0 waits; second target and queued/same-cycle pushes lost
      net_ack = 1'b0;
      expect_flit(64'h11, 10, 0);
      tick();
      drive_res(64'h11, tg(1, 10, 0), tg(1, 11, 1)); tick();
      drive_res(64'h22, tg(1, 12, 2), tg(0, 0, 0));  tick();
      res_valid = 1'b0;
      wait_req("t5_req");
      tick();
      flush = 1'b1;
      drive_res(64'h33, tg(1, 13, 0), tg(0, 0, 0));
      tick();
      flush     = 1'b0;
      res_valid = 1'b0;
      @(negedge clk);
      check("t5_occ_flushed", 128'(occupancy), 128'(1));
      check("t5_inflight", 128'({net_req, net_dest_instr, net_dest_slot}), 128'({1'b1, 7'd10, 2'd0}));
      tick();
      net_ack = 1'b1;
      tick();
      net_ack = 1'b0;
      @(negedge clk);
      check("t5_occ_after", 128'(occupancy), 128'(0));
      check("t5_no_tgt1", 128'(net_req), 128'(0));
      repeat (4) @(negedge clk);
      check("t5_still_idle", 128'(busy), 128'(0));
      check("t5_cnt", 128'(flits_sent), 128'(9));

      // 6: slot 3 target skipped and flagged; reset mid-request
      net_ack = 1'b1;
      expect_flit(64'h44, 21, 0);
      push_one(64'h44, tg(1, 20, 3), tg(1, 21, 0));
      @(negedge clk);
      check("t6_slot_err", 128'(slot_err), 128'(1));
      wait_idle("t6_idle");
      check("t6_cnt", 128'(flits_sent), 128'(10));
      net_ack = 1'b0;
      push_one(64'h55, tg(1, 22, 1), tg(0, 0, 0));
      wait_req("t6_req");
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("t6_rst");
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
